dds_freq_meter: RTL and testbench

- Receive-side companion to the DDS phase-accumulator generator: measures an incoming square wave, normally the DDS MSB output F_out, and recovers the frequency tuning word K that produced it.
- Counts synchronized rising edges over a fixed gate of 2^GATE_LOG2 clocks, then scales the count to a 32-bit K estimate.
- Used for loopback self-check of the DDS and for bench/board frequency readout.

---
 rtl/dds_pkg.sv | 20 ++
 rtl/dds_edge_sync.sv | 29 ++
 rtl/dds_freq_meter.sv | 117 +++++++++++
 tb/tb_dds_freq_meter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS generator and its frequency meter:
// accumulator width, meter FSM states and the count-to-K scaling.
package dds_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } meter_state_e;

  // An edge count over 2^gate_log2 clocks equals K / 2^(ACC_W-gate_log2),
  // so scaling back up is a plain left shift.
  function automatic logic [ACC_W-1:0] k_from_count(input logic [ACC_W-1:0] count,
                                                    input int unsigned       gate_log2);
    return count << (ACC_W - gate_log2);
  endfunction

endpackage

// File: rtl/dds_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous
// input. rise_o is high for one cycle per synchronized 0->1 transition.
module dds_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain (s1, s2) and edge history (s3), updated every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/dds_freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a gate
// of 2^GATE_LOG2 clocks and reports the count and the implied tuning word.
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int GATE_LOG2  = 16,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sig_in,
  output logic                 busy,
  output logic                 valid,
  output logic [GATE_LOG2-1:0] edge_cnt,
  output logic [ACC_W-1:0]     k_est
);

  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

  meter_state_e         state_q, state_d;
  logic [GATE_LOG2-1:0] gate_cnt_q, gate_cnt_d;
  logic [GATE_LOG2-1:0] acc_cnt_q, acc_cnt_d;
  logic [GATE_LOG2-1:0] edge_cnt_q, edge_cnt_d;
  logic [ACC_W-1:0]     k_est_q, k_est_d;
  logic                 valid_q, valid_d;
  logic [GATE_LOG2-1:0] acc_final;
  logic                 rise;

  // Edge accumulator increment; edges are at least two cycles apart so the
  // ceiling is never reached in practice, but the counter must not wrap.
  function automatic logic [GATE_LOG2-1:0] sat_inc(input logic [GATE_LOG2-1:0] v,
                                                   input logic                 inc);
    if (inc && (v != GATE_LAST)) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  dds_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (sig_in),
    .rise_o (rise)
  );

  // Next-state logic: gate sequencing, edge accumulation and result capture.
  // Results are captured on the last GATE cycle so they are visible together
  // with valid during the DONE cycle.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    edge_cnt_d = edge_cnt_q;
    k_est_d    = k_est_q;
    valid_d    = 1'b0;
    acc_final  = sat_inc(acc_cnt_q, rise);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          gate_cnt_d = '0;
          acc_cnt_d  = '0;
          state_d    = GATE;
        end
      end
      GATE: begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        acc_cnt_d  = acc_final;
        if (gate_cnt_q == GATE_LAST) begin
          edge_cnt_d = acc_final;
          k_est_d    = k_from_count(ACC_W'(acc_final), GATE_LOG2);
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        // A rise seen here is dropped: it belongs to neither gate.
        gate_cnt_d = '0;
        acc_cnt_d  = '0;
        if (CONTINUOUS) begin
          state_d = GATE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      acc_cnt_q  <= '0;
      edge_cnt_q <= '0;
      k_est_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      k_est_q    <= k_est_d;
      valid_q    <= valid_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign valid    = valid_q;
  assign edge_cnt = edge_cnt_q;
  assign k_est    = k_est_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter: a one-shot and a continuous instance share the
// measured signal; a window-based reference model is compared every cycle.
`timescale 1ns/1ps
module tb_dds_freq_meter;
  import dds_pkg::*;

  localparam int GL   = 8;
  localparam int GATE = 1 << GL;
  localparam int MAXC = 16384;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          sig_in   = 1'b0;
  logic          start_os = 1'b0;
  logic          start_ct = 1'b0;
  logic          busy_os, valid_os, busy_ct, valid_ct;
  logic [GL-1:0] edge_os, edge_ct;
  logic [31:0]   k_os, k_ct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_freq_meter #(.GATE_LOG2(GL), .CONTINUOUS(1'b0)) u_os (
    .clk(clk), .rst_n(rst_n), .start(start_os), .sig_in(sig_in),
    .busy(busy_os), .valid(valid_os), .edge_cnt(edge_os), .k_est(k_os)
  );

  dds_freq_meter #(.GATE_LOG2(GL), .CONTINUOUS(1'b1)) u_ct (
    .clk(clk), .rst_n(rst_n), .start(start_ct), .sig_in(sig_in),
    .busy(busy_ct), .valid(valid_ct), .edge_cnt(edge_ct), .k_est(k_ct)
  );

  // ---------------- signal source: constant, square wave or DDS MSB
  int          gen_mode  = 0;
  logic        gen_level = 1'b1;
  int          sq_period = 16;
  int          sq_ph     = 0;
  logic [31:0] dds_k     = 32'd0;
  logic [31:0] dds_acc   = 32'd0;

  initial forever begin
    @(posedge clk);
    #1;
    case (gen_mode)
      0: sig_in = gen_level;
      1: begin
        sq_ph  = (sq_ph + 1) % sq_period;
        sig_in = (sq_ph < sq_period / 2);
      end
      default: begin
        dds_acc = dds_acc + dds_k;
        sig_in  = dds_acc[31];
      end
    endcase
  end

  // ---------------- reference model
  // smp[n] is the input level captured at clock edge n (0 while in reset).
  // A rise is visible in the cycle after edge n when smp[n-1]=1, smp[n-2]=0.
  // A measurement started at edge w counts rises in the cycles after edges
  // w .. w+GATE-1 and reports in the cycle after edge w+GATE.
  bit            smp [0:MAXC-1];
  int            cyc = 0;
  bit            act     [2];
  int            ws      [2];
  bit            m_valid [2];
  bit            m_busy  [2];
  logic [GL-1:0] m_edge  [2];
  logic [31:0]   m_k     [2];

  function automatic bit smp_at(input int n);
    if (n < 0 || n >= MAXC) return 1'b0;
    return smp[n];
  endfunction

  function automatic int window_rises(input int w);
    int r = 0;
    for (int n = w; n < w + GATE; n++) begin
      if (smp_at(n - 1) && !smp_at(n - 2)) r++;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      act[i]     = 1'b0;
      ws[i]      = 0;
      m_valid[i] = 1'b0;
      m_busy[i]  = 1'b0;
      m_edge[i]  = '0;
      m_k[i]     = '0;
    end
  endtask

  initial forever begin
    @(negedge rst_n);
    model_clear();
  end

  initial forever begin
    @(posedge clk);
    if (cyc < MAXC) smp[cyc] = rst_n ? sig_in : 1'b0;
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit st;
        bit accept;
        st         = (i == 0) ? start_os : start_ct;
        accept     = !act[i] && st;
        m_valid[i] = 1'b0;
        if (act[i] && cyc == ws[i] + GATE) begin
          int r;
          r          = window_rises(ws[i]);
          m_edge[i]  = GL'(r);
          m_k[i]     = k_from_count(32'(r), GL);
          m_valid[i] = 1'b1;
        end
        if (act[i] && cyc == ws[i] + GATE + 1) begin
          if (i == 1) ws[i] = cyc;
          else        act[i] = 1'b0;
        end
        if (accept) begin
          act[i] = 1'b1;
          ws[i]  = cyc;
        end
        m_busy[i] = act[i];
      end
    end
    cyc++;
  end

  // ---------------- comparison helpers
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, got, exp_v);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("valid_os", 32'(valid_os), 32'(m_valid[0]));
      chk("busy_os",  32'(busy_os),  32'(m_busy[0]));
      chk("edge_os",  32'(edge_os),  32'(m_edge[0]));
      chk("k_os",     k_os,          m_k[0]);
      chk("valid_ct", 32'(valid_ct), 32'(m_valid[1]));
      chk("busy_ct",  32'(busy_ct),  32'(m_busy[1]));
      chk("edge_ct",  32'(edge_ct),  32'(m_edge[1]));
      chk("k_ct",     k_ct,          m_k[1]);
    end
  end

  // ---------------- stimulus tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int which, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    if (which == 0) start_os = 1'b1;
    else            start_ct = 1'b1;
    @(posedge clk);
    #1;
    start_os = 1'b0;
    start_ct = 1'b0;
  endtask

  task automatic wait_valid(input int which, input int budget, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0) ? valid_os : valid_ct) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid%0d: no valid within %0d cycles", which, budget);
    end
  endtask

  task automatic count_valids(input int which, input int n, output int nv);
    nv = 0;
    repeat (n) begin
      @(negedge clk);
      if ((which == 0) ? valid_os : valid_ct) nv++;
    end
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence
  initial begin
    int    t0, t1, at1, at2, at3, at4, nv;
    longint d;

    // Reset with a static high input.
    gen_mode  = 0;
    gen_level = 1'b1;
    cycles(3);
    chk("rst_busy",  32'(busy_os),  32'd0);
    chk("rst_valid", 32'(valid_os), 32'd0);
    chk("rst_edge",  32'(edge_os),  32'd0);
    chk("rst_k",     k_os,          32'd0);
    rst_n = 1'b1;
    cycles(10);

    // Static high since reset: no rise inside the gate.
    pulse_start(0, t0);
    wait_valid(0, 400, at1);
    chk("static_edge", 32'(edge_os), 32'd0);
    chk("static_k",    k_os,         32'd0);
    cycles(5);

    // Period-16 square wave: latency and count.
    sq_period = 16;
    sq_ph     = 0;
    gen_mode  = 1;
    cycles(40);
    pulse_start(0, t0);
    wait_valid(0, 400, at1);
    chk("lat16",   32'(at1 - t0), 32'd257);
    chk("p16_edge", 32'(edge_os), 32'd16);
    chk("p16_k",    k_os,         32'h1000_0000);
    cycles(5);

    // Toggling every clock.
    sq_period = 2;
    cycles(10);
    pulse_start(0, t0);
    wait_valid(0, 400, at1);
    chk("p2_edge", 32'(edge_os), 32'd128);
    chk("p2_k",    k_os,         32'h8000_0000);
    cycles(5);

    // DDS loopback, exact tuning word.
    dds_k    = 32'h0400_0000;
    dds_acc  = 32'd0;
    gen_mode = 2;
    cycles(10);
    pulse_start(0, t0);
    wait_valid(0, 400, at1);
    chk("dds_edge", 32'(edge_os), 32'd4);
    chk("dds_k",    k_os,         32'h0400_0000);

    // DDS loopback, non-power-of-two tuning word within one-edge accuracy.
    dds_k = 32'h0123_4567;
    cycles(10);
    pulse_start(0, t0);
    wait_valid(0, 400, at1);
    d = longint'(k_os) - longint'(32'h0123_4567);
    chk("dds_tol", 32'((d <= 64'sh0100_0000) && (d >= -64'sh0100_0000)), 32'd1);
    cycles(5);

    // Extra start pulses during GATE are ignored.
    sq_period = 16;
    sq_ph     = 0;
    gen_mode  = 1;
    cycles(20);
    pulse_start(0, t0);
    cycles(50);
    pulse_start(0, t1);
    cycles(100);
    pulse_start(0, t1);
    count_valids(0, 400, nv);
    chk("extra_nvalid", 32'(nv), 32'd1);
    chk("extra_busy",   32'(busy_os), 32'd0);
    chk("extra_edge",   32'(edge_os), 32'd16);

    // Reset around gate cycle 100, then a clean measurement.
    pulse_start(0, t0);
    cycles(98);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_os), 32'd0);
    chk("midrst_edge", 32'(edge_os), 32'd0);
    chk("midrst_k",    k_os,         32'd0);
    cycles(2);
    rst_n = 1'b1;
    count_valids(0, 300, nv);
    chk("midrst_nvalid", 32'(nv), 32'd0);
    pulse_start(0, t0);
    wait_valid(0, 400, at1);
    chk("after_rst_edge", 32'(edge_os), 32'd16);
    cycles(5);

    // Continuous mode: period 32, then 64 mid-run.
    sq_period = 32;
    sq_ph     = 0;
    cycles(20);
    pulse_start(1, t0);
    wait_valid(1, 400, at1);
    chk("ct_lat",   32'(at1 - t0), 32'd257);
    chk("ct_edge1", 32'(edge_ct),  32'd8);
    wait_valid(1, 400, at2);
    chk("ct_gap1",  32'(at2 - at1), 32'd257);
    chk("ct_edge2", 32'(edge_ct),   32'd8);
    chk("ct_busy",  32'(busy_ct),   32'd1);
    cycles(100);
    sq_period = 64;
    sq_ph     = 0;
    wait_valid(1, 400, at3);
    chk("ct_gap2",  32'(at3 - at2), 32'd257);
    chk("ct_edge3_range", 32'((edge_ct >= 8'd4) && (edge_ct <= 8'd8)), 32'd1);
    wait_valid(1, 400, at4);
    chk("ct_gap3",  32'(at4 - at3), 32'd257);
    chk("ct_edge4", 32'(edge_ct),   32'd4);
    chk("ct_k4",    k_ct,           32'h0400_0000);

    cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
